mem_uart_bridge: RTL and testbench

- Memory-side target of the MMU: consumes single read/write requests on the m_* interface and carries them to an external host memory over an 8N1 UART link.
- Serialises each request into a command frame and collects the host's response bytes.
- Returns read data or write acknowledgement to the MMU.
- Holds one transaction in flight; the MMU's request buffers provide all queuing.

---
 rtl/mem_uart_bridge_pkg.sv | 35 +++
 rtl/mem_uart_bridge_uart_byte_io.sv | 124 ++++++++++++
 rtl/mem_uart_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_mem_uart_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_uart_bridge_pkg.sv
// Shared definitions for the memory-to-UART bridge: widths, frame byte codes, FSM encoding.
package mem_uart_bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned RW_LEN_W   = 2;

    localparam logic [7:0] CMD_RD   = 8'h50;
    localparam logic [7:0] CMD_WR   = 8'h60;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [2:0] {
        StIdle,
        StTxCmd,
        StTxAddr,
        StTxData,
        StRxData,
        StRxAck,
        StDone,
        StHold
    } bridge_state_e;

    // Index of the final byte of a (1 << len)-byte payload.
    function automatic logic [2:0] last_byte_idx(input logic [RW_LEN_W-1:0] len);
        logic [2:0] idx;
        unique case (len)
            2'd0:    idx = 3'd0;
            2'd1:    idx = 3'd1;
            2'd2:    idx = 3'd3;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_uart_bridge_uart_byte_io.sv
// 8N1 byte transmitter (load/ready/busy) and receiver (2-flop sync, mid-bit sampling).
module uart_byte_io #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_load_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_frame_err_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

    logic             tx_busy_q;
    logic [DIV_W-1:0] tx_div_q;
    logic [3:0]       tx_bit_q;
    logic [8:0]       tx_shift_q;
    logic             tx_q;
    logic             tx_tick;

    assign tx_tick    = tx_busy_q && (tx_div_q == DIV_LAST);
    // Ready during the final stop-bit cycle so consecutive bytes run back-to-back.
    assign tx_ready_o = !tx_busy_q || (tx_tick && (tx_bit_q == 4'd9));
    assign tx_busy_o  = tx_busy_q;
    assign tx_o       = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q  <= 1'b0;
            tx_div_q   <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 9'h1ff;
            tx_q       <= 1'b1;
        end else if (tx_load_i && tx_ready_o) begin
            tx_busy_q  <= 1'b1;
            tx_div_q   <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= {1'b1, tx_data_i};
            tx_q       <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_tick) begin
                tx_div_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_div_q <= tx_div_q + 1'b1;
            end
        end
    end

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             rx_active_q;
    logic [DIV_W-1:0] rx_div_q;
    logic [3:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q;
    logic             rx_ferr_q;

    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_shift_q;
    assign rx_frame_err_o = rx_ferr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_active_q <= 1'b0;
            rx_div_q    <= '0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            if (!rx_active_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_active_q <= 1'b1;
                    rx_div_q    <= '0;
                    rx_bit_q    <= 4'd0;
                end
            end else if (rx_bit_q == 4'd0) begin
                // Re-check the start bit at half-bit to reject glitches.
                if (rx_div_q == DIV_HALF) begin
                    rx_div_q <= '0;
                    if (!rx_s2_q) rx_bit_q <= 4'd1;
                    else          rx_active_q <= 1'b0;
                end else begin
                    rx_div_q <= rx_div_q + 1'b1;
                end
            end else if (rx_div_q == DIV_LAST) begin
                rx_div_q <= '0;
                if (rx_bit_q == 4'd9) begin
                    rx_active_q <= 1'b0;
                    if (rx_s2_q) rx_valid_q <= 1'b1;
                    else         rx_ferr_q  <= 1'b1;
                end else begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_div_q <= rx_div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_uart_bridge.sv
// MMU memory target that tunnels single read/write requests to a host over an 8N1 UART.
// Define MEM_UART_TIMEOUT_EN to add a response watchdog that pulses err and completes early.
module mem_uart_bridge
    import mem_uart_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 434,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m_raddr,
    input  logic [RW_LEN_W-1:0] m_rlen,
    input  logic                m_re,
    output logic [DATA_W-1:0]   m_din,
    output logic                m_rack,
    input  logic [ADDR_W-1:0]   m_waddr,
    input  logic [RW_LEN_W-1:0] m_wlen,
    input  logic [DATA_W-1:0]   m_dout,
    input  logic                m_we,
    output logic                m_wack,
    input  logic                uart_rx,
    output logic                uart_tx,
    output logic                err
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_W / 8 - 1);

    bridge_state_e         state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [RW_LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rd_buf_q, rd_buf_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [2:0]            byte_cnt_q, byte_cnt_d;

    logic       tx_load, tx_ready, tx_busy;
    logic [7:0] tx_byte;
    logic       rx_valid, rx_frame_err;
    logic [7:0] rx_data;
    logic       rx_timeout;

    uart_byte_io #(
        .CLK_DIV(CLK_DIV)
    ) u_uart (
        .clk           (clk),
        .rst           (rst),
        .tx_load_i     (tx_load),
        .tx_data_i     (tx_byte),
        .tx_ready_o    (tx_ready),
        .tx_busy_o     (tx_busy),
        .tx_o          (uart_tx),
        .rx_i          (uart_rx),
        .rx_valid_o    (rx_valid),
        .rx_data_o     (rx_data),
        .rx_frame_err_o(rx_frame_err)
    );

    logic unused_sigs;
    assign unused_sigs = ^{tx_busy, rx_frame_err};

`ifdef MEM_UART_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            in_rx;

    assign in_rx      = (state_q == StRxData) || (state_q == StRxAck);
    assign rx_timeout = in_rx && !rx_valid && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= rx_timeout;
            if (!in_rx || rx_valid) wd_q <= '0;
            else if (!rx_timeout)   wd_q <= wd_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign rx_timeout     = 1'b0;
    assign err            = 1'b0;
`endif

    assign m_din = din_q;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        din_d      = din_q;
        byte_cnt_d = byte_cnt_q;
        tx_load    = 1'b0;
        tx_byte    = 8'h00;
        m_rack     = 1'b0;
        m_wack     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Write wins when both request lines are up.
                if (m_we) begin
                    is_wr_d    = 1'b1;
                    addr_d     = m_waddr;
                    len_d      = m_wlen;
                    wdata_d    = m_dout;
                    byte_cnt_d = 3'd0;
                    state_d    = StTxCmd;
                end else if (m_re) begin
                    is_wr_d    = 1'b0;
                    addr_d     = m_raddr;
                    len_d      = m_rlen;
                    rd_buf_d   = '0;
                    byte_cnt_d = 3'd0;
                    state_d    = StTxCmd;
                end
            end
            StTxCmd: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = (is_wr_q ? CMD_WR : CMD_RD) | {6'b0, len_q};
                    state_d = StTxAddr;
                end
            end
            StTxAddr: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = 8'(addr_q >> {byte_cnt_q, 3'b000});
                    if (byte_cnt_q == ADDR_LAST) begin
                        byte_cnt_d = 3'd0;
                        state_d    = is_wr_q ? StTxData : StRxData;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            StTxData: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = wdata_q[{byte_cnt_q, 3'b000} +: 8];
                    if (byte_cnt_q == last_byte_idx(len_q)) begin
                        byte_cnt_d = 3'd0;
                        state_d    = StRxAck;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            StRxData: begin
                if (rx_valid) begin
                    rd_buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    if (byte_cnt_q == last_byte_idx(len_q)) begin
                        byte_cnt_d = 3'd0;
                        din_d      = rd_buf_d;
                        state_d    = StDone;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end else if (rx_timeout) begin
                    din_d   = rd_buf_q;
                    state_d = StDone;
                end
            end
            StRxAck: begin
                if ((rx_valid && (rx_data == ACK_BYTE)) || rx_timeout) state_d = StDone;
            end
            StDone: begin
                m_rack  = !is_wr_q;
                m_wack  = is_wr_q;
                state_d = StHold;
            end
            StHold: begin
                // Wait for the serviced line to drop so one request is not taken twice.
                if (is_wr_q ? !m_we : !m_re) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            is_wr_q    <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_buf_q   <= '0;
            din_q      <= '0;
            byte_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_buf_q   <= rd_buf_d;
            din_q      <= din_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Bench for mem_uart_bridge: host UART model, TX byte scoreboard and ack/read-data scoreboard.
module tb_mem_uart_bridge;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_raddr = '0;
    logic [1:0]  m_rlen = '0;
    logic        m_re = 1'b0;
    logic [63:0] m_din;
    logic        m_rack;
    logic [31:0] m_waddr = '0;
    logic [1:0]  m_wlen = '0;
    logic [63:0] m_dout = '0;
    logic        m_we = 1'b0;
    logic        m_wack;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        err;

    mem_uart_bridge #(
        .CLK_DIV    (DIV),
        .ADDR_W     (32),
        .DATA_W     (64),
        .TIMEOUT_CYC(500)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_raddr(m_raddr),
        .m_rlen (m_rlen),
        .m_re   (m_re),
        .m_din  (m_din),
        .m_rack (m_rack),
        .m_waddr(m_waddr),
        .m_wlen (m_wlen),
        .m_dout (m_dout),
        .m_we   (m_we),
        .m_wack (m_wack),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rack_cnt = 0;
    int wack_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  got_tx[$];
    logic [7:0]  exp_tx[$];
    logic [63:0] got_rd[$];
    logic [63:0] exp_rd[$];

    // Host-side decoder of the bridge's serial output.
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge uart_tx);
            repeat (DIV / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                mon_b[i] = uart_tx;
            end
            repeat (DIV) @(posedge clk);
            got_tx.push_back(mon_b);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_rack) begin
                rack_cnt++;
                got_rd.push_back(m_din);
            end
            if (m_wack) wack_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic host_send(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (got_tx.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_ack(input bit wr, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if ((wr ? wack_cnt : rack_cnt) >= target) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic push_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input int ndata, input logic [63:0] data);
        exp_tx.push_back(cmd);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(addr >> (8 * i)));
        for (int i = 0; i < ndata; i++) exp_tx.push_back(8'(data >> (8 * i)));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b exp 1", uart_tx); end
        if (m_rack !== 1'b0) begin errors++; $display("FAIL reset_rack: got %b exp 0", m_rack); end
        if (m_wack !== 1'b0) begin errors++; $display("FAIL reset_wack: got %b exp 0", m_wack); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        if (m_din !== 64'h0) begin errors++; $display("FAIL reset_din: got %h exp 0", m_din); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read8();
        bit ok;
        int r0;
        logic [7:0] g, e;
        logic [63:0] gd, ed;
        r0 = rack_cnt;
        push_frame(8'h53, 32'h0000_1000, 0, 64'h0);
        exp_rd.push_back(64'h8877_6655_4433_2211);
        m_raddr = 32'h0000_1000; m_rlen = 2'd3; m_re = 1'b1;
        wait_tx(5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd8_tx_count: got %0d bytes exp 5", got_tx.size()); end
        for (int i = 0; i < 5; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rd8_tx[%0d]: got %h exp %h", i, g, e); end
        end
        for (int k = 1; k <= 8; k++) host_send(8'(8'h11 * k));
        wait_ack(1'b0, r0 + 1, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (rack_cnt != r0 + 1) begin
            errors++; $display("FAIL rd8_rack_pulses: got %0d exp 1", rack_cnt - r0);
        end
        gd = (got_rd.size() > 0) ? got_rd.pop_front() : 64'hx;
        ed = exp_rd.pop_front();
        checks++;
        if (gd !== ed) begin errors++; $display("FAIL rd8_din: got %h exp %h", gd, ed); end
        m_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write2();
        bit ok;
        int w0;
        logic [7:0] g, e;
        w0 = wack_cnt;
        push_frame(8'h61, 32'h0000_0204, 2, 64'hBEEF);
        m_waddr = 32'h0000_0204; m_wlen = 2'd1; m_dout = 64'h0000_0000_0000_BEEF; m_we = 1'b1;
        @(negedge clk);
        m_dout = 64'h1234_5678_9ABC_DEF0;
        wait_tx(7, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr2_tx_count: got %0d bytes exp 7", got_tx.size()); end
        for (int i = 0; i < 7; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL wr2_tx[%0d]: got %h exp %h", i, g, e); end
        end
        host_send(8'h42);
        repeat (8) @(negedge clk);
        checks++;
        if (wack_cnt != w0) begin errors++; $display("FAIL wr2_nonack: got %0d acks exp 0", wack_cnt - w0); end
        host_send(8'h06);
        wait_ack(1'b1, w0 + 1, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (wack_cnt != w0 + 1) begin
            errors++; $display("FAIL wr2_wack_pulses: got %0d exp 1", wack_cnt - w0);
        end
        m_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int r0, w0;
        logic [7:0] g, e;
        logic [63:0] gd, ed;
        r0 = rack_cnt; w0 = wack_cnt;
        push_frame(8'h60, 32'h0000_0010, 1, 64'h5A);
        push_frame(8'h50, 32'h0000_0020, 0, 64'h0);
        exp_rd.push_back(64'h77);
        m_waddr = 32'h10; m_wlen = 2'd0; m_dout = 64'h5A;
        m_raddr = 32'h20; m_rlen = 2'd0;
        m_we = 1'b1; m_re = 1'b1;
        wait_tx(6, ok);
        for (int i = 0; i < 6; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_wr_tx[%0d]: got %h exp %h", i, g, e); end
        end
        host_send(8'h06);
        wait_ack(1'b1, w0 + 1, 200, ok);
        m_we = 1'b0;
        checks++;
        if (rack_cnt != r0) begin errors++; $display("FAIL b2b_rd_early: got %0d racks exp 0", rack_cnt - r0); end
        wait_tx(5, ok);
        for (int i = 0; i < 5; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_rd_tx[%0d]: got %h exp %h", i, g, e); end
        end
        host_send(8'h77);
        wait_ack(1'b0, r0 + 1, 200, ok);
        repeat (10) @(negedge clk);
        checks += 3;
        if (wack_cnt != w0 + 1) begin errors++; $display("FAIL b2b_wack: got %0d exp 1", wack_cnt - w0); end
        if (rack_cnt != r0 + 1) begin errors++; $display("FAIL b2b_rack: got %0d exp 1", rack_cnt - r0); end
        gd = (got_rd.size() > 0) ? got_rd.pop_front() : 64'hx;
        ed = exp_rd.pop_front();
        if (gd !== ed) begin errors++; $display("FAIL b2b_din: got %h exp %h", gd, ed); end
        m_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_hold();
        bit ok;
        int r0;
        logic [7:0] g, e;
        r0 = rack_cnt;
        push_frame(8'h50, 32'h0000_0030, 0, 64'h0);
        exp_rd.push_back(64'h99);
        m_raddr = 32'h30; m_rlen = 2'd0; m_re = 1'b1;
        wait_tx(5, ok);
        for (int i = 0; i < 5; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL hold_tx[%0d]: got %h exp %h", i, g, e); end
        end
        host_send(8'h99);
        wait_ack(1'b0, r0 + 1, 200, ok);
        repeat (50) @(negedge clk);
        checks += 3;
        if (got_tx.size() != 0) begin errors++; $display("FAIL hold_no_resend: got %0d bytes exp 0", got_tx.size()); end
        if (rack_cnt != r0 + 1) begin errors++; $display("FAIL hold_rack: got %0d exp 1", rack_cnt - r0); end
        if (got_rd.size() > 0 && got_rd[0] !== exp_rd[0]) begin
            errors++; $display("FAIL hold_din: got %h exp %h", got_rd[0], exp_rd[0]);
        end
        void'(got_rd.pop_front());
        void'(exp_rd.pop_front());
        m_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int r0;
        logic [7:0] g, e;
        logic [63:0] gd, ed;
        r0 = rack_cnt;
        m_raddr = 32'h1234_5678; m_rlen = 2'd1; m_re = 1'b1;
        wait_tx(3, ok);
        repeat (2 * DIV) @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 2;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b exp 1", uart_tx); end
        if (m_rack !== 1'b0) begin errors++; $display("FAIL midrst_rack: got %b exp 0", m_rack); end
        m_re = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        got_tx.delete();
        push_frame(8'h52, 32'hCAFE_0000, 0, 64'h0);
        exp_rd.push_back(64'h0403_0201);
        m_raddr = 32'hCAFE_0000; m_rlen = 2'd2; m_re = 1'b1;
        wait_tx(5, ok);
        for (int i = 0; i < 5; i++) begin
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            e = exp_tx.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL midrst_tx[%0d]: got %h exp %h", i, g, e); end
        end
        for (int k = 1; k <= 4; k++) host_send(8'(k));
        wait_ack(1'b0, r0 + 1, 200, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL midrst_rack: got %0d exp 1", rack_cnt - r0); end
        gd = (got_rd.size() > 0) ? got_rd.pop_front() : 64'hx;
        ed = exp_rd.pop_front();
        if (gd !== ed) begin errors++; $display("FAIL midrst_din: got %h exp %h", gd, ed); end
        m_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

`ifdef MEM_UART_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int r0, e0;
        logic [63:0] gd, ed;
        r0 = rack_cnt; e0 = err_cnt;
        push_frame(8'h52, 32'h0000_0040, 0, 64'h0);
        exp_rd.push_back(64'h0000_0000_0000_00AA);
        m_raddr = 32'h40; m_rlen = 2'd2; m_re = 1'b1;
        wait_tx(5, ok);
        got_tx.delete();
        exp_tx.delete();
        host_send(8'hAA);
        wait_ack(1'b0, r0 + 1, 1500, ok);
        repeat (5) @(negedge clk);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL tmo_rack: got %0d exp 1", rack_cnt - r0); end
        if (err_cnt != e0 + 1) begin errors++; $display("FAIL tmo_err: got %0d exp 1", err_cnt - e0); end
        gd = (got_rd.size() > 0) ? got_rd.pop_front() : 64'hx;
        ed = exp_rd.pop_front();
        if (gd !== ed) begin errors++; $display("FAIL tmo_din: got %h exp %h", gd, ed); end
        m_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        int exp_err;
        exp_err = 0;
        test_reset();
        test_read8();
        test_write2();
        test_back_to_back();
        test_hold();
        test_reset_midframe();
`ifdef MEM_UART_TIMEOUT_EN
        test_timeout();
        exp_err = 1;
`endif
        checks++;
        if (err_cnt != exp_err) begin errors++; $display("FAIL err_total: got %0d exp %0d", err_cnt, exp_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1, "bench time limit");
    end

endmodule
